// File: rtl/int_sched_pkg.sv
// -----------------------------------------------------------------------------
// int_sched_pkg
// Shared types and helpers for the int_sched interrupt scheduler.
//   NUM_IRQ_DEF : default number of interrupt lines
//   MAX_IRQ     : widest vector the helpers handle (NUM_IRQ must not exceed it)
//   state_t     : request FSM states (IDLE / REQ)
//   hi_t        : highest-set-index result (valid flag + index)
//   highest()   : highest set index of a vector
//   above_vec() : indices strictly greater than a hi_t index (all when !valid)
// -----------------------------------------------------------------------------
package int_sched_pkg;

  localparam int NUM_IRQ_DEF = 8;
  localparam int MAX_IRQ     = 32;
  localparam int IDX_W       = $clog2(MAX_IRQ);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } hi_t;

  function automatic hi_t highest(input logic [MAX_IRQ-1:0] v);
    hi_t r;
    r = '0;
    // Ascending scan: the last hit is the highest index.
    for (int i = 0; i < MAX_IRQ; i++) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = i[IDX_W-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [MAX_IRQ-1:0] above_vec(input hi_t h);
    logic [MAX_IRQ-1:0] r;
    r = '1;
    if (h.valid) begin
      for (int i = 0; i < MAX_IRQ; i++) begin
        r[i] = (i > int'(h.idx));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// -----------------------------------------------------------------------------
// int_prio_enc
// Combinational highest-index priority encoder.
//   vec : input request vector (WIDTH bits)
//   hi  : {valid, index of highest set bit}
// -----------------------------------------------------------------------------
module int_prio_enc
  import int_sched_pkg::*;
#(
  parameter int WIDTH = NUM_IRQ_DEF
) (
  input  logic [WIDTH-1:0] vec,
  output hi_t              hi
);

  logic [MAX_IRQ-1:0] ext;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ext            = '0;
    ext[WIDTH-1:0] = vec;
  end

  assign hi = highest(ext);

endmodule

// File: rtl/int_sched.sv
// -----------------------------------------------------------------------------
// int_sched
// Interrupt scheduler feeding the CP0 hardware_interrupt input. Raw levels are
// edge-detected into pending requests, masked, and arbitrated by fixed
// priority (higher index wins) against the nested in-service levels. The
// winner is held as a one-hot request until CP0 acknowledges it.
//
// Ports:
//   clk, clr_n  : clock, asynchronous active-low reset
//   irq_in      : raw interrupt levels (rising edge requests service)
//   cfg_we      : mask write strobe, cfg_mask the new mask
//   int_ack     : CP0 took the offered request
//   eret        : handler returned, retire top in-service level
//   ovr_clr     : clear all overrun flags
//   hw_int      : one-hot request to CP0
//   pending     : latched, unacknowledged requests
//   in_service  : acknowledged, unretired levels
//   overrun     : sticky, edge arrived while already pending
//   mask        : current mask register
//
// Build option: define INT_SCHED_IRQ_SYNC_EN to pass irq_in through a
// two-flop synchronizer (adds 2 cycles of latency, allows async irq_in).
// -----------------------------------------------------------------------------
module int_sched
  import int_sched_pkg::*;
#(
  parameter int                 NUM_IRQ  = NUM_IRQ_DEF,
  parameter logic [NUM_IRQ-1:0] RST_MASK = '0
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cfg_we,
  input  logic [NUM_IRQ-1:0] cfg_mask,
  input  logic               int_ack,
  input  logic               eret,
  input  logic               ovr_clr,
  output logic [NUM_IRQ-1:0] hw_int,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service,
  output logic [NUM_IRQ-1:0] overrun,
  output logic [NUM_IRQ-1:0] mask
);

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] edge_v;

`ifdef INT_SCHED_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync_q1;
  logic [NUM_IRQ-1:0] sync_q2;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_in;
      sync_q2 <= sync_q1;
    end
  end

  assign irq_s = sync_q2;
`else
  assign irq_s = irq_in;
`endif

  assign edge_v = irq_s & ~irq_prev;

  // Arbitration.
  hi_t                isr_hi;
  hi_t                win_hi;
  logic [NUM_IRQ-1:0] above;
  logic [NUM_IRQ-1:0] cand;

  int_prio_enc #(.WIDTH(NUM_IRQ)) u_isr_enc (.vec(in_service), .hi(isr_hi));

  assign above = NUM_IRQ'(above_vec(isr_hi));
  assign cand  = pending & mask & above;

  int_prio_enc #(.WIDTH(NUM_IRQ)) u_cand_enc (.vec(cand), .hi(win_hi));

  // Request FSM.
  state_t             state, state_nxt;
  logic [IDX_W-1:0]   id_q, id_nxt;
  logic [NUM_IRQ-1:0] hw_nxt;
  logic [NUM_IRQ-1:0] id_vec;
  logic               ack_take;

  assign id_vec = NUM_IRQ'(1) << id_q;

  always_comb begin
    state_nxt = state;
    id_nxt    = id_q;
    hw_nxt    = hw_int;
    ack_take  = 1'b0;
    unique case (state)
      IDLE: begin
        hw_nxt = '0;
        if (win_hi.valid) begin
          id_nxt    = win_hi.idx;
          hw_nxt    = NUM_IRQ'(1) << win_hi.idx;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (int_ack) begin
          ack_take  = 1'b1;
          hw_nxt    = '0;
          state_nxt = IDLE;
        end else if (!(|(id_vec & mask & above))) begin
          // Request lost eligibility; pending is kept and re-arbitrated.
          hw_nxt    = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        hw_nxt    = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Next-state for the status vectors.
  logic [NUM_IRQ-1:0] ack_vec;
  logic [NUM_IRQ-1:0] ret_vec;
  logic [NUM_IRQ-1:0] pend_nxt;
  logic [NUM_IRQ-1:0] isr_nxt;
  logic [NUM_IRQ-1:0] ovr_nxt;

  always_comb begin
    ack_vec = ack_take ? id_vec : '0;
    ret_vec = (eret && isr_hi.valid) ? (NUM_IRQ'(1) << isr_hi.idx) : '0;
    // A fresh edge on the acked line re-arms pending and is not an overrun.
    pend_nxt = (pending & ~ack_vec) | edge_v;
    ovr_nxt  = (ovr_clr ? '0 : overrun) | (edge_v & pending & ~ack_vec);
    // Retire from the pre-update in_service, then record the ack.
    isr_nxt  = (in_service & ~ret_vec) | ack_vec;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      id_q       <= '0;
      hw_int     <= '0;
      irq_prev   <= '0;
      pending    <= '0;
      in_service <= '0;
      overrun    <= '0;
      mask       <= RST_MASK;
    end else begin
      state      <= state_nxt;
      id_q       <= id_nxt;
      hw_int     <= hw_nxt;
      irq_prev   <= irq_s;
      pending    <= pend_nxt;
      in_service <= isr_nxt;
      overrun    <= ovr_nxt;
      if (cfg_we) begin
        mask <= cfg_mask;
      end
    end
  end

endmodule

// File: tb/tb_int_sched.sv
// -----------------------------------------------------------------------------
// tb_int_sched
// Directed self-checking bench for int_sched (default build, synchronous
// irq_in). Inputs change and outputs are sampled 1ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_int_sched;

  logic       clk;
  logic       clr_n;
  logic [7:0] irq_in;
  logic       cfg_we;
  logic [7:0] cfg_mask;
  logic       int_ack;
  logic       eret;
  logic       ovr_clr;
  logic [7:0] hw_int;
  logic [7:0] pending;
  logic [7:0] in_service;
  logic [7:0] overrun;
  logic [7:0] mask;

  int n_checks = 0;
  int n_pass   = 0;

  int_sched #(
    .NUM_IRQ (8),
    .RST_MASK(8'h00)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .irq_in    (irq_in),
    .cfg_we    (cfg_we),
    .cfg_mask  (cfg_mask),
    .int_ack   (int_ack),
    .eret      (eret),
    .ovr_clr   (ovr_clr),
    .hw_int    (hw_int),
    .pending   (pending),
    .in_service(in_service),
    .overrun   (overrun),
    .mask      (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] actual,
                       input logic [7:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulses, applied for exactly one rising edge.
  task automatic ack_pulse();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic eret_pulse();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] m);
    cfg_we   = 1'b1;
    cfg_mask = m;
    tick();
    cfg_we   = 1'b0;
  endtask

  initial begin
    clr_n    = 1'b0;
    irq_in   = '0;
    cfg_we   = 1'b0;
    cfg_mask = '0;
    int_ack  = 1'b0;
    eret     = 1'b0;
    ovr_clr  = 1'b0;

    // Reset state.
    #2;
    check("rst_hw_int", hw_int, 8'h00);
    check("rst_pending", pending, 8'h00);
    check("rst_mask", mask, 8'h00);
    tick();
    tick();
    clr_n = 1'b1;
    tick();

    // Basic offer and ack on line 3.
    write_mask(8'hFF);
    check("mask_wr", mask, 8'hFF);
    irq_in = 8'h08;
    tick();
    check("basic_pend", pending, 8'h08);
    check("basic_hw_early", hw_int, 8'h00);
    tick();
    check("basic_hw", hw_int, 8'h08);
    ack_pulse();
    check("basic_ack_hw", hw_int, 8'h00);
    check("basic_ack_pend", pending, 8'h00);
    check("basic_ack_isr", in_service, 8'h08);
    irq_in = 8'h00;
    eret_pulse();
    check("basic_eret_isr", in_service, 8'h00);
    tick();

    // Priority and blocking: lines 2 and 5 together.
    irq_in = 8'h24;
    tick();
    tick();
    check("prio_hw", hw_int, 8'h20);
    ack_pulse();
    check("prio_isr", in_service, 8'h20);
    check("prio_pend", pending, 8'h04);
    tick();
    tick();
    check("prio_blocked", hw_int, 8'h00);
    eret_pulse();
    check("prio_eret_isr", in_service, 8'h00);
    tick();
    check("prio_low_hw", hw_int, 8'h04);
    ack_pulse();
    check("prio_low_isr", in_service, 8'h04);
    irq_in = 8'h00;
    tick();

    // Nesting: line 6 above in-service line 2.
    irq_in = 8'h40;
    tick();
    tick();
    check("nest_hw", hw_int, 8'h40);
    ack_pulse();
    check("nest_isr", in_service, 8'h44);
    eret_pulse();
    check("nest_eret1", in_service, 8'h04);
    eret_pulse();
    check("nest_eret2", in_service, 8'h00);
    eret_pulse();
    check("nest_eret_empty", in_service, 8'h00);
    irq_in = 8'h00;
    tick();

    // Overrun on line 1.
    irq_in = 8'h02;
    tick();
    irq_in = 8'h00;
    tick();
    irq_in = 8'h02;
    tick();
    check("ovr_pend", pending, 8'h02);
    check("ovr_flag", overrun, 8'h02);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr_flag", overrun, 8'h00);
    check("ovr_clr_pend", pending, 8'h02);
    check("ovr_hw", hw_int, 8'h02);
    ack_pulse();
    eret_pulse();
    check("ovr_done_isr", in_service, 8'h00);
    irq_in = 8'h00;
    tick();

    // Ack with a same-cycle edge on the acked line: pending re-arms, no overrun.
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tick();
    check("ackedge_hw", hw_int, 8'h01);
    irq_in  = 8'h01;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("ackedge_pend", pending, 8'h01);
    check("ackedge_ovr", overrun, 8'h00);
    check("ackedge_isr", in_service, 8'h01);
    // Line 0 is not above itself; retire and drain the re-armed request.
    eret_pulse();
    tick();
    check("ackedge_reoffer", hw_int, 8'h01);
    ack_pulse();
    eret_pulse();
    irq_in = 8'h00;
    tick();

    // Mask withdraw on line 4.
    irq_in = 8'h10;
    tick();
    tick();
    check("wd_hw", hw_int, 8'h10);
    write_mask(8'hEF);
    check("wd_hw_oldmask", hw_int, 8'h10);
    tick();
    check("wd_hw_withdrawn", hw_int, 8'h00);
    check("wd_pend", pending, 8'h10);
    write_mask(8'hFF);
    tick();
    check("wd_hw_restored", hw_int, 8'h10);

    // Async reset mid-request on line 7 (nested above line 4).
    ack_pulse();
    irq_in = 8'h80;
    tick();
    tick();
    check("ar_hw", hw_int, 8'h80);
    check("ar_isr", in_service, 8'h10);
    #2;
    clr_n = 1'b0;
    #1;
    check("ar_hw_zero", hw_int, 8'h00);
    check("ar_pend_zero", pending, 8'h00);
    check("ar_isr_zero", in_service, 8'h00);
    check("ar_ovr_zero", overrun, 8'h00);
    check("ar_mask_rst", mask, 8'h00);
    tick();
    clr_n  = 1'b1;
    irq_in = 8'h00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
